ad7705_responder: RTL and testbench
===================================

# ad7705_responder

Synthesizable model of the AD7705 serial interface, acting as the SPI responder to the volt meter's SPI master. It decodes comms-register writes and accepts setup/clock writes. It serves comms and data-register reads, and models DRDY, self-calibration and ADC reset. It feeds MISO from a supplied 16-bit sample stream, so the ADC state machine can be checked in simulation or on a second board without the real part.

## Interface
- CAL_CYCLES, 1024: clk cycles that DRDY is held high after a self-calibration request.
- SYNC_STAGES, 2: synchronizer depth on SCK, MOSI and adc_reset.
- clk  in  1  system clock; must run at ≥8× the SCK frequency.
- reset  in  1  one clock; reset is asynchronous and active-low.
- SCK  in  1  serial clock from the master; idles high.
- MOSI  in  1  serial data from the master, MSB first.
- adc_reset  in  1  part reset from the master, active-low, synchronized.
- sample  in  16  next conversion result, unipolar code.
- sample_valid  in  1  one-cycle strobe that loads `sample`.
- MISO  out  1  serial data to the master; reset value 1.
- drdy_n  out  1  data-ready, active-low; reset value 1.
- setup_reg  out  8  current setup register; reset value 0x01.
- clock_reg  out  8  current clock register; reset value 0x05.
- cal_busy  out  1  self-calibration in progress; reset value 0.

## Operation
- **Edge detection.** SCK, MOSI and adc_reset pass through SYNC_STAGES flops.
  - A rising SCK edge shifts in the synchronized MOSI.
  - A falling SCK edge advances MISO.
- **State machine (COMMS, WRITE, READ).**
  - **COMMS.** Receive 8 bits, decoded as {0/DRDY, RS[2:0], R/W, STBY, CH[1:0]}.
    - If bit 7 is 1, discard the byte and stay in COMMS.
    - Otherwise latch RS, STBY and CH.
    - R/W=0: go to WRITE. R/W=1: load the transmit shifter and go to READ.
  - **Register widths by RS.**
    - 8 bits: comms 000, setup 001, clock 010, test 100.
    - 16 bits: data 011.
    - 24 bits: offset 110, gain 111.
    - No-op 101: 8 bits.
  - **WRITE.** After width bits, commit the value and return to COMMS.
    - Setup and clock values are stored.
    - Data and no-op writes are discarded.
    - Test, offset and gain values are discarded.
  - **READ.** Shift out width bits MSB first, then return to COMMS.
    - Comms reads return {drdy_n, RS, 1, STBY, CH}.
    - Data reads return the data register.
    - Setup and clock reads return their registers.
    - All other registers read as 0.
  - MISO is 1 outside READ.
- **Data register.** A `sample_valid` pulse loads the data register and drives drdy_n low.
  - drdy_n goes high when the 16th bit of a data read has been shifted out.
  - A sample arriving during a data read goes into a one-deep pending buffer.
    - The buffer is applied when the read ends, and drdy_n is then low.
    - A second sample arriving while the buffer is occupied overwrites it.
- **Self-calibration.** Triggered by a setup write with MD[7:6]=01.
  - cal_busy=1 and drdy_n=1 for CAL_CYCLES clk cycles.
  - sample_valid is ignored during calibration.
  - When calibration ends, MD clears to 00. drdy_n stays high until the next sample.
  - MD=10 or 11 behaves the same as 01.
- **FSYNC.** While setup bit 0 is 1, samples are ignored and drdy_n=1.
- **ADC reset and module reset.** Either a synchronized adc_reset low or reset low returns everything to reset values.
  - The state machine goes to COMMS and the bit counter clears.
  - This holds in any state, including mid-frame.
  - adc_reset is level-sensitive.

## Timing
- **MISO latency.** MISO changes 3 clk cycles after the physical falling SCK edge (SYNC_STAGES+1).
  - The SCK high and low half-periods must each be ≥4 clk.
- **MISO transition points.**
  - The first READ bit is valid within 3 clk after the rising edge that captures the last comms bit.
  - The remaining bits change on falling edges only.
- **Register commit.** Setup and clock values update 1 clk after the edge that captures their last bit.
  - cal_busy rises in the same cycle.
- **Calibration end.** cal_busy falls exactly CAL_CYCLES clk after it rises.
- **drdy_n.** Falls 1 clk after `sample_valid`.
  - Rises 1 clk after the falling edge that follows the last data bit.
- **Simultaneous events.**
  - `sample_valid` in the same cycle as the final data bit: the pending rule applies.
  - adc_reset asserted in the same cycle as a commit: the reset wins.

## Configuration
- AD7705_RESYNC_EN defined:
  - 32 consecutive 1s on MOSI in any state force the state machine to COMMS.
  - The bit counter clears. Registers are unchanged.
- AD7705_RESYNC_EN undefined:
  - The ones-counter is absent.
  - Only adc_reset or reset re-frames the interface.

## Structure
- Package ad7705_pkg holds:
  - the rs_e enum of the 8 register selects;
  - the st_e state enum;
  - constants SETUP_RST=0x01, CLOCK_RST=0x05, MD_SELFCAL=2'b01;
  - a width function mapping rs_e to 8, 16 or 24.
- Sub-module sck_sync is natural: the synchronizers for SCK, MOSI and adc_reset, plus rise/fall strobes for SCK.

## Test plan
- **Clock write.** Reset, then write 0x20 followed by 0x0C → clock_reg=0x0C. MISO stays 1 throughout.
- **Self-calibration.** Write 0x10 followed by 0x44 → setup_reg=0x44, cal_busy high for 1024 clk, then setup_reg=0x04.
  - sample_valid with 0x1234 during calibration is ignored; drdy_n stays 1.
- **Data read.** sample=0x3333 → drdy_n=0.
  - Write 0x08 and read 8 bits → 0x08 (DRDY bit 0).
  - Write 0x38 and read 16 bits → 0x3333, drdy_n=1.
  - A following comms read returns 0x88.
- **Pending sample.** sample_valid with 0xAAAA at bit 9 of a read of 0x5555 → the read returns 0x5555 and drdy_n is low afterwards.
  - The next read returns 0xAAAA.
- **adc_reset mid-frame.** adc_reset low after 5 bits of a setup write → registers return to 0x01/0x05.
  - The next full 0x20/0x0C sequence commits correctly.
- **Resync, AD7705_RESYNC_EN defined.** Send 3 stray bits, then 32 ones, then 0x20/0x0C → clock_reg=0x0C.
  - Without the macro, the same stimulus leaves clock_reg=0x05.

Source files
------------

// File: rtl/ad7705_pkg.sv
// Shared types and constants for the AD7705 serial-interface responder.
package ad7705_pkg;

  typedef enum logic [2:0] {
    RS_COMMS  = 3'd0,
    RS_SETUP  = 3'd1,
    RS_CLOCK  = 3'd2,
    RS_DATA   = 3'd3,
    RS_TEST   = 3'd4,
    RS_NOOP   = 3'd5,
    RS_OFFSET = 3'd6,
    RS_GAIN   = 3'd7
  } rs_e;

  typedef enum logic [1:0] {
    ST_COMMS = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } st_e;

  typedef struct packed {
    st_e        state;
    rs_e        rs;
    logic       stby;
    logic [1:0] ch;
    logic [4:0] bit_cnt;
  } dbg_t;

  localparam logic [7:0] SETUP_RST  = 8'h01;
  localparam logic [7:0] CLOCK_RST  = 8'h05;
  localparam logic [1:0] MD_SELFCAL = 2'b01;

  function automatic logic [4:0] rs_width(input rs_e rs);
    case (rs)
      RS_DATA:           return 5'd16;
      RS_OFFSET, RS_GAIN: return 5'd24;
      default:           return 5'd8;
    endcase
  endfunction

endpackage

// File: rtl/ad7705_responder_sck_sync.sv
// Synchronizers for SCK, MOSI and adc_reset, plus one-cycle SCK rise/fall strobes.
module sck_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_i,
  input  logic mosi_i,
  input  logic adc_reset_n_i,
  output logic mosi_o,
  output logic adc_reset_n_o,
  output logic sck_rise_o,
  output logic sck_fall_o
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] arst_q;
  logic                   sck_prev_q;
  logic                   sck_s;

  // SCK idles high and adc_reset is inactive high, so the chains reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q      <= '1;
      mosi_q     <= '0;
      arst_q     <= '1;
      sck_prev_q <= 1'b1;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      arst_q     <= {arst_q[SYNC_STAGES-2:0], adc_reset_n_i};
      sck_prev_q <= sck_s;
    end
  end

  assign sck_s         = sck_q[SYNC_STAGES-1];
  assign mosi_o        = mosi_q[SYNC_STAGES-1];
  assign adc_reset_n_o = arst_q[SYNC_STAGES-1];
  assign sck_rise_o    = sck_s & ~sck_prev_q;
  assign sck_fall_o    = ~sck_s & sck_prev_q;

endmodule

// File: rtl/ad7705_responder.sv
// AD7705 SPI responder: comms decode, setup/clock registers, data reads, DRDY, self-cal.
// Optional AD7705_RESYNC_EN: 32 consecutive MOSI ones re-frame the interface.
module ad7705_responder
  import ad7705_pkg::*;
#(
  parameter int CAL_CYCLES  = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCK,
  input  logic        MOSI,
  input  logic        adc_reset,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic        MISO,
  output logic        drdy_n,
  output logic [7:0]  setup_reg,
  output logic [7:0]  clock_reg,
  output logic        cal_busy,
  output dbg_t        dbg_o
);

  localparam int CAL_W = $clog2(CAL_CYCLES + 1);

  logic mosi_s, adc_rst_n_s, sck_rise, sck_fall;

  sck_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk           (clk),
    .rst_n         (reset),
    .sck_i         (SCK),
    .mosi_i        (MOSI),
    .adc_reset_n_i (adc_reset),
    .mosi_o        (mosi_s),
    .adc_reset_n_o (adc_rst_n_s),
    .sck_rise_o    (sck_rise),
    .sck_fall_o    (sck_fall)
  );

  st_e             state_q;
  rs_e             rs_q;
  logic            stby_q;
  logic [1:0]      ch_q;
  logic [4:0]      bit_cnt_q, width_q;
  logic [6:0]      rx_q;
  logic [22:0]     tx_q;
  logic [7:0]      setup_q, clock_q;
  logic [15:0]     data_q, pend_q;
  logic            pend_vld_q, drdy_n_q, cal_busy_q, miso_q;
  logic [CAL_W-1:0] cal_cnt_q;
`ifdef AD7705_RESYNC_EN
  logic [4:0]      ones_q;
`endif

  logic [7:0]  rx_byte;
  logic [23:0] rd_value;
  logic        sample_ok, read_done;

  // sample_valid is a one-cycle strobe with no backpressure: an accepted
  // sample is either loaded, or parked in the pending slot during a data read.
  assign rx_byte   = {rx_q, mosi_s};
  assign sample_ok = sample_valid && !cal_busy_q && !setup_q[0];
  assign read_done = (state_q == ST_READ) && sck_fall && (bit_cnt_q == width_q);

  always_comb begin
    rd_value = '0;
    case (rs_e'(rx_byte[6:4]))
      RS_COMMS: rd_value = {drdy_n_q, rx_byte[6:0], 16'h0};
      RS_SETUP: rd_value = {setup_q, 16'h0};
      RS_CLOCK: rd_value = {clock_q, 16'h0};
      RS_DATA:  rd_value = {data_q, 8'h0};
      default:  rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_COMMS;  rs_q <= RS_COMMS;  stby_q <= 1'b0;  ch_q <= '0;
      bit_cnt_q <= '0;  width_q <= 5'd8;  rx_q <= '0;  tx_q <= '0;
      setup_q <= SETUP_RST;  clock_q <= CLOCK_RST;  data_q <= '0;  pend_q <= '0;
      pend_vld_q <= 1'b0;  drdy_n_q <= 1'b1;  cal_busy_q <= 1'b0;  miso_q <= 1'b1;
      cal_cnt_q <= '0;
`ifdef AD7705_RESYNC_EN
      ones_q <= '0;
`endif
    end else if (!adc_rst_n_s) begin
      state_q <= ST_COMMS;  rs_q <= RS_COMMS;  stby_q <= 1'b0;  ch_q <= '0;
      bit_cnt_q <= '0;  width_q <= 5'd8;  rx_q <= '0;  tx_q <= '0;
      setup_q <= SETUP_RST;  clock_q <= CLOCK_RST;  data_q <= '0;  pend_q <= '0;
      pend_vld_q <= 1'b0;  drdy_n_q <= 1'b1;  cal_busy_q <= 1'b0;  miso_q <= 1'b1;
      cal_cnt_q <= '0;
`ifdef AD7705_RESYNC_EN
      ones_q <= '0;
`endif
    end else begin
      if (cal_busy_q) begin
        if (cal_cnt_q == '0) begin
          cal_busy_q   <= 1'b0;
          setup_q[7:6] <= 2'b00;
        end else begin
          cal_cnt_q <= cal_cnt_q - 1'b1;
        end
      end

      if (sample_ok) begin
        if (state_q == ST_READ && rs_q == RS_DATA && !read_done) begin
          pend_q     <= sample;
          pend_vld_q <= 1'b1;
        end else begin
          data_q   <= sample;
          drdy_n_q <= 1'b0;
        end
      end

      case (state_q)
        ST_COMMS: if (sck_rise) begin
          rx_q <= rx_byte[6:0];
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_q <= '0;
            if (!rx_byte[7]) begin
              rs_q    <= rs_e'(rx_byte[6:4]);
              stby_q  <= rx_byte[2];
              ch_q    <= rx_byte[1:0];
              width_q <= rs_width(rs_e'(rx_byte[6:4]));
              if (rx_byte[3]) begin
                tx_q    <= rd_value[22:0];
                miso_q  <= rd_value[23];
                state_q <= ST_READ;
              end else begin
                state_q <= ST_WRITE;
              end
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end

        ST_WRITE: if (sck_rise) begin
          rx_q <= rx_byte[6:0];
          if (bit_cnt_q == width_q - 5'd1) begin
            bit_cnt_q <= '0;
            state_q   <= ST_COMMS;
            if (rs_q == RS_SETUP) begin
              setup_q <= rx_byte;
              if (rx_byte[7:6] >= MD_SELFCAL) begin
                cal_busy_q <= 1'b1;
                cal_cnt_q  <= CAL_W'(CAL_CYCLES - 1);
                drdy_n_q   <= 1'b1;
              end
              if (rx_byte[0]) drdy_n_q <= 1'b1;
            end else if (rs_q == RS_CLOCK) begin
              clock_q <= rx_byte;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end

        // Rises count bits the master has taken; the first fall holds bit 0,
        // and the fall after the last bit closes the frame.
        ST_READ: begin
          if (sck_rise && bit_cnt_q != width_q) bit_cnt_q <= bit_cnt_q + 5'd1;
          if (sck_fall) begin
            if (bit_cnt_q == width_q) begin
              state_q   <= ST_COMMS;
              bit_cnt_q <= '0;
              miso_q    <= 1'b1;
              if (rs_q == RS_DATA) begin
                pend_vld_q <= 1'b0;
                if (!sample_ok) begin
                  if (pend_vld_q) begin
                    data_q   <= pend_q;
                    drdy_n_q <= 1'b0;
                  end else begin
                    drdy_n_q <= 1'b1;
                  end
                end
              end
            end else if (bit_cnt_q != '0) begin
              miso_q <= tx_q[22];
              tx_q   <= {tx_q[21:0], 1'b0};
            end
          end
        end

        default: state_q <= ST_COMMS;
      endcase

`ifdef AD7705_RESYNC_EN
      if (sck_rise) begin
        if (!mosi_s) begin
          ones_q <= '0;
        end else if (ones_q == 5'd31) begin
          ones_q    <= '0;
          state_q   <= ST_COMMS;
          bit_cnt_q <= '0;
          miso_q    <= 1'b1;
        end else begin
          ones_q <= ones_q + 5'd1;
        end
      end
`endif
    end
  end

  assign MISO      = miso_q;
  assign drdy_n    = drdy_n_q;
  assign setup_reg = setup_q;
  assign clock_reg = clock_q;
  assign cal_busy  = cal_busy_q;
  assign dbg_o     = '{state: state_q, rs: rs_q, stby: stby_q, ch: ch_q, bit_cnt: bit_cnt_q};

endmodule

// File: tb/tb_ad7705_responder.sv
// Directed bench for ad7705_responder with an expected-value queue and a monitor.
module tb_ad7705_responder;
  import ad7705_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b1;
  logic        mosi = 1'b0;
  logic        adc_reset = 1'b1;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        miso, drdy_n, cal_busy;
  logic [7:0]  setup_reg, clock_reg;
  dbg_t        dbg;

  ad7705_responder #(.CAL_CYCLES(1024), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .SCK          (sck),
    .MOSI         (mosi),
    .adc_reset    (adc_reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .MISO         (miso),
    .drdy_n       (drdy_n),
    .setup_reg    (setup_reg),
    .clock_reg    (clock_reg),
    .cal_busy     (cal_busy),
    .dbg_o        (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [23:0] exp_q[$];
  logic [23:0] act_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  initial begin
    forever begin
      @(negedge clk);
      while (act_q.size() > 0) begin
        logic [23:0] a, e;
        string       n;
        a = act_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0h required nothing", a);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", n, a, e);
          end
        end
      end
    end
  end

  // calibration length watcher
  int   cyc = 0, cal_rise = 0, cal_fall = 0;
  logic cal_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (cal_busy && !cal_prev) cal_rise = cyc;
    if (!cal_busy && cal_prev) cal_fall = cyc;
    cal_prev = cal_busy;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "bench time limit");
  end

  // driver tasks
  task automatic expect_out(input string name, input logic [23:0] e);
    name_q.push_back(name);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [23:0] e, input logic [23:0] a);
    expect_out(name, e);
    act_q.push_back(a);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    @(negedge clk);
    sck  = 1'b0;
    mosi = b;
    repeat (5) @(negedge clk);
    r   = miso;
    sck = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [23:0] tx, input int n, output logic [23:0] rx);
    logic r;
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic [23:0] d;
    spi_xfer({16'h0, b}, 8, d);
  endtask

  task automatic read_reg(input string name, input logic [7:0] cmd, input int n,
                          input logic [23:0] e);
    logic [23:0] rx;
    write_byte(cmd);
    expect_out(name, e);
    spi_xfer(24'h0, n, rx);
    act_q.push_back(rx);
  endtask

  task automatic pulse_sample(input logic [15:0] v);
    @(negedge clk);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic adc_reset_pulse();
    @(negedge clk);
    adc_reset = 1'b0;
    repeat (5) @(negedge clk);
    adc_reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // stimulus
  initial begin
    logic [23:0] rx, rx_hi, rx_lo;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_setup", 24'h01, {16'h0, setup_reg});
    check("rst_clock", 24'h05, {16'h0, clock_reg});
    check("rst_drdy", 24'h1, {23'h0, drdy_n});
    check("rst_cal_busy", 24'h0, {23'h0, cal_busy});
    check("rst_miso", 24'h1, {23'h0, miso});
    check("rst_state", 24'(ST_COMMS), 24'(dbg.state));

    // clock register write
    spi_xfer(24'h00200C, 16, rx);
    check("miso_idle_on_write", 24'h00FFFF, rx);
    check("clock_write", 24'h0C, {16'h0, clock_reg});

    // self-calibration
    write_byte(8'h10);
    write_byte(8'h44);
    check("setup_commit", 24'h44, {16'h0, setup_reg});
    check("cal_busy_set", 24'h1, {23'h0, cal_busy});
    pulse_sample(16'h1234);
    check("drdy_during_cal", 24'h1, {23'h0, drdy_n});
    for (int i = 0; i < 1500; i++) begin
      if (!cal_busy) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("cal_busy_clear", 24'h0, {23'h0, cal_busy});
    check("cal_length", 24'd1024, 24'(cal_fall - cal_rise));
    check("setup_md_cleared", 24'h04, {16'h0, setup_reg});
    check("drdy_after_cal", 24'h1, {23'h0, drdy_n});

    // data read
    pulse_sample(16'h3333);
    check("drdy_on_sample", 24'h0, {23'h0, drdy_n});
    read_reg("comms_rd_ready", 8'h08, 8, 24'h08);
    read_reg("data_rd", 8'h38, 16, 24'h3333);
    read_reg("comms_rd_idle", 8'h08, 8, 24'h88);
    check("drdy_after_data_rd", 24'h1, {23'h0, drdy_n});
    read_reg("setup_rd", 8'h18, 8, 24'h04);
    read_reg("clock_rd", 8'h28, 8, 24'h0C);
    read_reg("gain_rd", 8'h78, 24, 24'h0);

    // sample arriving mid data read
    pulse_sample(16'h5555);
    check("drdy_second_sample", 24'h0, {23'h0, drdy_n});
    write_byte(8'h38);
    expect_out("pend_rd_current", 24'h5555);
    spi_xfer(24'h0, 9, rx_hi);
    pulse_sample(16'hAAAA);
    spi_xfer(24'h0, 7, rx_lo);
    act_q.push_back({8'h0, rx_hi[8:0], rx_lo[6:0]});
    read_reg("pend_comms_rd", 8'h08, 8, 24'h08);
    read_reg("pend_data_rd", 8'h38, 16, 24'hAAAA);

    // adc_reset in the middle of a setup write
    write_byte(8'h10);
    spi_xfer(24'h000008, 5, rx);
    adc_reset_pulse();
    check("adcrst_setup", 24'h01, {16'h0, setup_reg});
    check("adcrst_clock", 24'h05, {16'h0, clock_reg});
    check("adcrst_state", 24'(ST_COMMS), 24'(dbg.state));
    check("adcrst_bitcnt", 24'h0, {19'h0, dbg.bit_cnt});
    write_byte(8'h20);
    write_byte(8'h0C);
    check("clock_after_adcrst", 24'h0C, {16'h0, clock_reg});

    // stray bits followed by a run of ones
    adc_reset_pulse();
    check("clock_before_resync", 24'h05, {16'h0, clock_reg});
    spi_xfer(24'h0, 3, rx);
    spi_xfer(24'hFFFFFF, 24, rx);
    spi_xfer(24'h0000FF, 8, rx);
    write_byte(8'h20);
    write_byte(8'h0C);
`ifdef AD7705_RESYNC_EN
    check("clock_after_ones", 24'h0C, {16'h0, clock_reg});
`else
    check("clock_after_ones", 24'h05, {16'h0, clock_reg});
`endif

    // final report
    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      string n;
      logic [23:0] e;
      n = name_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no output required %0h", n, e);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
